dma_quiesce: RTL and testbench
==============================

Name: dma_quiesce

Overview:
- DMA-side responder to the soft-reset controller's halt/quiet handshake.
- Tracks outstanding TX and RX DMA transactions and blocks new grants once halt is requested.
- Asserts tx_quiet / rx_quiet independently, each after its direction has fully drained and stayed idle.
- Sits between the DMA engine request/completion signals and the soft-reset controller.

Parameters:
- MAX_OUTSTANDING, 8: maximum in-flight transactions per direction; range 1..2^CNT_W-1.
- CNT_W, 4: width of the outstanding counters.
- QUIET_DLY, 4: consecutive cycles a counter must hold zero in DRAIN before quiet asserts; range ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- dma_halt  in  1  halt request from soft-reset controller; level
- soft_rst  in  1  synchronous soft reset from controller; clears counters and error
- tx_req  in  1  DMA engine requests to start a TX transaction
- tx_gnt  out  1  TX start granted this cycle
- tx_cpl  in  1  one TX transaction completed
- rx_req  in  1  DMA engine requests to start an RX transaction
- rx_gnt  out  1  RX start granted this cycle
- rx_cpl  in  1  one RX transaction completed
- tx_quiet  out  1  TX side dormant
- rx_quiet  out  1  RX side dormant
- tx_outstanding  out  CNT_W  TX in-flight count
- rx_outstanding  out  CNT_W  RX in-flight count
- cpl_err  out  1  sticky: completion received with counter at zero

Behaviour:
- Reset (rst=1 at clk edge): both FSMs enter RUN; counters=0; quiet timers=0; tx_quiet=rx_quiet=0; cpl_err=0.
- Combinational outputs: tx_gnt=rx_gnt=0 while rst=1.
- TX and RX are identical, independent instances; TX is described below.
- Grant (combinational from registered state): tx_gnt = tx_req & state==RUN & tx_outstanding<MAX_OUTSTANDING & !soft_rst.
- Counter update, next cycle:
  - +1 on tx_gnt only; -1 on tx_cpl only; unchanged on gnt and cpl in the same cycle.
  - tx_cpl with count==0 and no gnt: count stays 0, cpl_err set.
  - Counter never exceeds MAX_OUTSTANDING and never wraps.
- soft_rst=1: counters forced to 0 and cpl_err cleared next cycle; cpl and gnt are ignored that cycle. FSM state is not affected.
- FSM states RUN, DRAIN, QUIET:
  - RUN: tx_quiet=0. dma_halt=1 -> DRAIN; the timer clears.
  - DRAIN: no grants.
    - Timer increments each cycle with count==0 and clears when count!=0.
    - Timer reaching QUIET_DLY-1 with count==0 -> QUIET.
    - dma_halt=0 -> RUN (takes priority over reaching QUIET).
  - QUIET: tx_quiet=1 (registered, asserted the cycle the state is entered). No grants.
    - dma_halt=0 -> RUN; tx_quiet deasserts the next cycle.
    - A stray tx_cpl in QUIET sets cpl_err; the count stays 0 and the state stays QUIET.
- Latency: with count already 0 when dma_halt rises at cycle N, tx_quiet=1 at cycle N+1+QUIET_DLY.
- tx_gnt drops in the cycle after the dma_halt rise is sampled. A grant in the same cycle as the first dma_halt=1 is allowed and counted.
- cpl_err is shared by TX and RX; only rst or soft_rst clears it.

Test Plan:
- Idle halt: counts 0, QUIET_DLY=4, raise dma_halt at cycle 10 -> tx_quiet=rx_quiet=1 at cycle 15; tx_gnt=0 from cycle 11 despite tx_req=1.
- Drain:
  - Grant 3 TX, then raise dma_halt -> tx_quiet stays 0.
  - Return 3 tx_cpl on cycles 20, 22, 24 -> tx_outstanding reaches 0 at cycle 25; tx_quiet=1 at cycle 29.
  - rx_quiet asserts independently, earlier.
- Saturation and simultaneous events:
  - Hold tx_req=1 -> exactly 8 grants, then tx_gnt=0 at count 8.
  - Assert tx_cpl alongside tx_req -> count holds at 8 with one grant per cpl.
- Underflow: tx_cpl with count 0 -> cpl_err=1 and count stays 0; soft_rst pulse -> cpl_err=0 next cycle.
- Halt abort: dma_halt high for 2 cycles with count 0 and QUIET_DLY=4, then low -> tx_quiet never asserts; grants resume the cycle after dma_halt=0 is sampled.
- Mid-operation resets:
  - In QUIET with dma_halt=1, pulse soft_rst -> quiet stays 1 and counters stay 0. Drop dma_halt -> tx_quiet=0 next cycle.
  - rst with count 5 -> count 0, state RUN, all outputs 0.

Source files
------------

// File: rtl/dma_quiesce_if.sv
// Groups the halt/quiet handshake, the DMA request/grant/completion strobes and the status outputs of dma_quiesce.
// Latency: none; this file only bundles wires.
// Backpressure: none; grants are qualified by the responder, and requesters hold req until they see gnt.
interface dma_quiesce_if #(
  parameter int CNT_W = 4
);
  logic             dma_halt;
  logic             soft_rst;
  logic             tx_req;
  logic             tx_gnt;
  logic             tx_cpl;
  logic             rx_req;
  logic             rx_gnt;
  logic             rx_cpl;
  logic             tx_quiet;
  logic             rx_quiet;
  logic [CNT_W-1:0] tx_outstanding;
  logic [CNT_W-1:0] rx_outstanding;
  logic             cpl_err;

  // Requester side: the DMA engine and the soft-reset controller together.
  modport master (
    output dma_halt, soft_rst, tx_req, tx_cpl, rx_req, rx_cpl,
    input  tx_gnt, rx_gnt, tx_quiet, rx_quiet, tx_outstanding, rx_outstanding, cpl_err
  );

  // Responder side: the quiesce block.
  modport slave (
    input  dma_halt, soft_rst, tx_req, tx_cpl, rx_req, rx_cpl,
    output tx_gnt, rx_gnt, tx_quiet, rx_quiet, tx_outstanding, rx_outstanding, cpl_err
  );
endinterface

// File: rtl/dma_quiesce.sv
// One direction of the quiesce logic: counts in-flight transactions, gates grants, and reports quiet after a halt.
// Latency: gnt is combinational from registered state; quiet rises QUIET_DLY+1 cycles after halt when already idle.
// Backpressure: gnt is withheld at MAX_OUTSTANDING, during soft_rst, and in any state other than RUN.
module dma_quiesce_chan #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 4,
  parameter int QUIET_DLY       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             soft_rst,
  input  logic             req,
  input  logic             cpl,
  output logic             gnt,
  output logic             quiet,
  output logic [CNT_W-1:0] outstanding,
  output logic             underflow
);
  // The timer only has to reach QUIET_DLY-1, so size it for that value.
  localparam int TMR_W = (QUIET_DLY > 1) ? $clog2(QUIET_DLY) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(QUIET_DLY - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_QUIET = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q;
  logic             quiet_q;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // Grants are only issued from RUN, below the in-flight ceiling, and never while either reset is active.
  assign gnt = req & (state_q == ST_RUN) & (cnt_q < MAX_CNT) & ~soft_rst & ~rst;

  // A completion that finds nothing outstanding is an error unless a grant in the same cycle balances it.
  assign underflow = cpl & ~gnt & cnt_zero & ~soft_rst;

  assign quiet       = quiet_q;
  assign outstanding = cnt_q;

  // State, timer and registered quiet flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      timer_q <= '0;
      quiet_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      quiet_q <= (state_d == ST_QUIET);
    end
  end

  // Next state: halt drains, an idle counter held long enough declares quiet, and dropping halt always returns to RUN.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_RUN: begin
        if (halt) begin
          state_d = ST_DRAIN;
          timer_d = '0;
        end
      end
      ST_DRAIN: begin
        if (!halt) begin
          state_d = ST_RUN;
        end else if (cnt_zero && (timer_q == TMR_LAST)) begin
          state_d = ST_QUIET;
        end else if (cnt_zero) begin
          timer_d = timer_q + TMR_W'(1);
        end else begin
          timer_d = '0;
        end
      end
      ST_QUIET: begin
        if (!halt) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        timer_d = '0;
      end
    endcase
  end

  // Outstanding counter: soft_rst wins, a grant and completion together cancel, and zero never wraps.
  always_ff @(posedge clk) begin
    if (rst || soft_rst) begin
      cnt_q <= '0;
    end else if (gnt && !cpl) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (cpl && !gnt && !cnt_zero) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt_q <= MAX_CNT);
  a_gnt_run:   assert property (@(posedge clk) disable iff (rst) gnt |-> (state_q == ST_RUN));
  a_quiet_idle: assert property (@(posedge clk) disable iff (rst) quiet_q |-> cnt_zero);
endmodule

// Quiesce responder for the soft-reset controller: independent TX and RX drain tracking plus a shared completion error.
// Latency: grants combinational; quiet per direction QUIET_DLY+1 cycles after halt once that direction is empty.
// Backpressure: each direction withholds its grant at MAX_OUTSTANDING, under soft_rst, and once halt has been sampled.
module dma_quiesce #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 4,
  parameter int QUIET_DLY       = 4
) (
  input  logic        clk,
  input  logic        rst,
  dma_quiesce_if.slave bus
);
  logic tx_underflow;
  logic rx_underflow;
  logic cpl_err_q;

  dma_quiesce_chan #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W),
    .QUIET_DLY       (QUIET_DLY)
  ) u_tx (
    .clk         (clk),
    .rst         (rst),
    .halt        (bus.dma_halt),
    .soft_rst    (bus.soft_rst),
    .req         (bus.tx_req),
    .cpl         (bus.tx_cpl),
    .gnt         (bus.tx_gnt),
    .quiet       (bus.tx_quiet),
    .outstanding (bus.tx_outstanding),
    .underflow   (tx_underflow)
  );

  dma_quiesce_chan #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W),
    .QUIET_DLY       (QUIET_DLY)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .halt        (bus.dma_halt),
    .soft_rst    (bus.soft_rst),
    .req         (bus.rx_req),
    .cpl         (bus.rx_cpl),
    .gnt         (bus.rx_gnt),
    .quiet       (bus.rx_quiet),
    .outstanding (bus.rx_outstanding),
    .underflow   (rx_underflow)
  );

  // Sticky error shared by both directions; only a full or soft reset clears it.
  always_ff @(posedge clk) begin
    if (rst || bus.soft_rst) begin
      cpl_err_q <= 1'b0;
    end else if (tx_underflow || rx_underflow) begin
      cpl_err_q <= 1'b1;
    end
  end

  assign bus.cpl_err = cpl_err_q;
endmodule

// File: tb/tb_dma_quiesce.sv
module tb_dma_quiesce;
  localparam int MAXO = 8;
  localparam int CW   = 4;
  localparam int QD   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dma_quiesce_if #(.CNT_W(CW)) bus ();

  dma_quiesce #(
    .MAX_OUTSTANDING (MAXO),
    .CNT_W           (CW),
    .QUIET_DLY       (QD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a direction is blocked whenever halt was high last cycle; it goes quiet once it has
  // seen QD consecutive halted-and-empty cycles after the first halt cycle, and stays quiet while halt holds.
  int   m_cnt  [2];
  int   m_zrun [2];
  logic m_quiet[2];
  logic m_err;
  logic m_prev_halt;

  function automatic logic m_gnt(input int d);
    logic r;
    r = (d == 1) ? bus.rx_req : bus.tx_req;
    return r && !rst && !bus.soft_rst && !m_prev_halt && (m_cnt[d] < MAXO);
  endfunction

  function automatic logic [12:0] m_exp();
    logic [3:0] c0;
    logic [3:0] c1;
    c0 = 4'(m_cnt[0]);
    c1 = 4'(m_cnt[1]);
    return {m_gnt(0), m_gnt(1), m_quiet[0], m_quiet[1], c0, c1, m_err};
  endfunction

  function automatic logic [12:0] obs();
    return {bus.tx_gnt, bus.rx_gnt, bus.tx_quiet, bus.rx_quiet,
            bus.tx_outstanding, bus.rx_outstanding, bus.cpl_err};
  endfunction

  always @(posedge clk) begin
    logic g;
    logic c;
    logic uf;
    uf = 1'b0;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_cnt[d] = 0; m_zrun[d] = 0; m_quiet[d] = 1'b0;
      end
      m_err = 1'b0;
      m_prev_halt = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        g = m_gnt(d);
        c = (d == 1) ? bus.rx_cpl : bus.tx_cpl;
        if (m_prev_halt && !m_quiet[d]) m_zrun[d] = (m_cnt[d] == 0) ? m_zrun[d] + 1 : 0;
        else m_zrun[d] = 0;
        m_quiet[d] = bus.dma_halt && (m_quiet[d] || (m_zrun[d] >= QD));
        if (bus.soft_rst) m_cnt[d] = 0;
        else if (g && !c) m_cnt[d] = m_cnt[d] + 1;
        else if (c && !g) begin
          if (m_cnt[d] == 0) uf = 1'b1;
          else m_cnt[d] = m_cnt[d] - 1;
        end
      end
      if (bus.soft_rst) m_err = 1'b0;
      else if (uf) m_err = 1'b1;
      m_prev_halt = bus.dma_halt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic h, input logic sr, input logic tr, input logic tc,
                       input logic rr, input logic rc);
    bus.dma_halt = h;
    bus.soft_rst = sr;
    bus.tx_req   = tr;
    bus.tx_cpl   = tc;
    bus.rx_req   = rr;
    bus.rx_cpl   = rc;
  endtask

  task automatic clean();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [12:0] o;
    logic [12:0] e;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    o = obs();
    tests++;
    if (o !== 13'h0) begin fails++; $display("FAIL reset_hold got %h want %h", o, 13'h0); end
    e = m_exp();
    tests++;
    if (o !== e) begin fails++; $display("FAIL reset_model got %h want %h", o, e); end
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    o = obs();
    tests++;
    if (o !== 13'h0) begin fails++; $display("FAIL reset_after got %h want %h", o, 13'h0); end
    tick();
  endtask

  task automatic test_idle_halt();
    logic [12:0] o;
    logic [12:0] e;
    logic eg;
    logic eq;
    for (int k = -2; k <= 8; k++) begin
      drive(k >= 0 && k <= 6, 1'b0, k >= 1, 1'b0, k >= 1, 1'b0);
      @(negedge clk);
      o = obs(); e = m_exp();
      tests++;
      if (o !== e) begin fails++; $display("FAIL idle_model k=%0d got %h want %h", k, o, e); end
      if (k >= 1) begin
        eg = (k >= 8);
        eq = (k >= 5 && k <= 7);
        tests++;
        if (bus.tx_gnt !== eg) begin fails++; $display("FAIL idle_gnt k=%0d got %b want %b", k, bus.tx_gnt, eg); end
        tests++;
        if ({bus.tx_quiet, bus.rx_quiet} !== {eq, eq}) begin
          fails++; $display("FAIL idle_quiet k=%0d got %b%b want %b%b", k, bus.tx_quiet, bus.rx_quiet, eq, eq);
        end
      end
      tick();
    end
    clean();
  endtask

  task automatic test_drain();
    logic [12:0] o;
    logic [12:0] e;
    for (int k = -3; k <= 13; k++) begin
      drive(k >= 0 && k <= 12, 1'b0, k < 0, k == 2 || k == 4 || k == 6, k == -3, k == 1);
      @(negedge clk);
      o = obs(); e = m_exp();
      tests++;
      if (o !== e) begin fails++; $display("FAIL drain_model k=%0d got %h want %h", k, o, e); end
      if (k >= 0) begin
        tests++;
        if (bus.tx_quiet !== (k >= 11)) begin fails++; $display("FAIL drain_txq k=%0d got %b want %b", k, bus.tx_quiet, k >= 11); end
        tests++;
        if (bus.rx_quiet !== (k >= 6)) begin fails++; $display("FAIL drain_rxq k=%0d got %b want %b", k, bus.rx_quiet, k >= 6); end
      end
      if (k == 0 || k == 7) begin
        tests++;
        if (bus.tx_outstanding !== ((k == 0) ? 4'd3 : 4'd0)) begin
          fails++; $display("FAIL drain_cnt k=%0d got %0d want %0d", k, bus.tx_outstanding, (k == 0) ? 3 : 0);
        end
      end
      tick();
    end
    clean();
  endtask

  task automatic test_saturation();
    logic [12:0] o;
    logic [12:0] e;
    int g1;
    int g2;
    g1 = 0; g2 = 0;
    for (int k = 0; k <= 19; k++) begin
      drive(1'b0, 1'b0, 1'b1, k >= 12 && k <= 15, 1'b0, 1'b0);
      @(negedge clk);
      o = obs(); e = m_exp();
      tests++;
      if (o !== e) begin fails++; $display("FAIL sat_model k=%0d got %h want %h", k, o, e); end
      if (k <= 11 && bus.tx_gnt === 1'b1) g1++;
      if (k >= 12 && k <= 16 && bus.tx_gnt === 1'b1) g2++;
      if (k == 11 || k == 17) begin
        tests++;
        if ({bus.tx_gnt, bus.tx_outstanding} !== {1'b0, 4'd8}) begin
          fails++; $display("FAIL sat_full k=%0d got gnt=%b cnt=%0d want gnt=0 cnt=8", k, bus.tx_gnt, bus.tx_outstanding);
        end
      end
      tick();
    end
    tests++;
    if (g1 != 8) begin fails++; $display("FAIL sat_grants got %0d want 8", g1); end
    tests++;
    if (g2 != 4) begin fails++; $display("FAIL sat_refill got %0d want 4", g2); end
    clean();
  endtask

  task automatic test_underflow();
    logic [12:0] o;
    logic [12:0] e;
    logic ee;
    for (int k = 0; k <= 8; k++) begin
      drive(1'b0, k == 2 || k == 5, k == 7, k == 0 || k == 7, 1'b0, k == 4);
      @(negedge clk);
      o = obs(); e = m_exp();
      tests++;
      if (o !== e) begin fails++; $display("FAIL uf_model k=%0d got %h want %h", k, o, e); end
      ee = (k == 1 || k == 2 || k == 5);
      tests++;
      if ({bus.cpl_err, bus.tx_outstanding} !== {ee, 4'd0}) begin
        fails++; $display("FAIL uf_err k=%0d got err=%b cnt=%0d want err=%b cnt=0", k, bus.cpl_err, bus.tx_outstanding, ee);
      end
      tick();
    end
    clean();
  endtask

  task automatic test_halt_abort();
    logic [12:0] o;
    logic [12:0] e;
    for (int k = 0; k <= 8; k++) begin
      drive(k <= 1, 1'b0, k >= 1, 1'b0, k >= 1, 1'b0);
      @(negedge clk);
      o = obs(); e = m_exp();
      tests++;
      if (o !== e) begin fails++; $display("FAIL abort_model k=%0d got %h want %h", k, o, e); end
      tests++;
      if ({bus.tx_gnt, bus.tx_quiet, bus.rx_quiet} !== {k >= 3, 1'b0, 1'b0}) begin
        fails++; $display("FAIL abort_gq k=%0d got %b%b%b want %b00", k, bus.tx_gnt, bus.tx_quiet, bus.rx_quiet, k >= 3);
      end
      tick();
    end
    clean();
  endtask

  task automatic test_mid_reset();
    logic [12:0] o;
    logic [12:0] e;
    logic r;
    for (int k = 0; k <= 17; k++) begin
      r = ((k >= 10 && k <= 14) || k >= 16);
      rst = (k == 15);
      drive(k <= 8 || k == 14 || k == 15, k == 7, r, 1'b0, r, 1'b0);
      @(negedge clk);
      o = obs(); e = m_exp();
      tests++;
      if (o !== e) begin fails++; $display("FAIL mid_model k=%0d got %h want %h", k, o, e); end
      if (k <= 14) begin
        tests++;
        if (bus.tx_quiet !== (k >= 5 && k <= 9)) begin
          fails++; $display("FAIL mid_quiet k=%0d got %b want %b", k, bus.tx_quiet, k >= 5 && k <= 9);
        end
      end
      if (k == 8) begin
        tests++;
        if ({bus.tx_outstanding, bus.rx_outstanding} !== 8'h00) begin
          fails++; $display("FAIL mid_soft_cnt got %h want 00", {bus.tx_outstanding, bus.rx_outstanding});
        end
      end
      if (k == 15) begin
        tests++;
        if ({bus.tx_gnt, bus.tx_outstanding} !== {1'b0, 4'd5}) begin
          fails++; $display("FAIL mid_prerst got gnt=%b cnt=%0d want gnt=0 cnt=5", bus.tx_gnt, bus.tx_outstanding);
        end
      end
      if (k == 16) begin
        tests++;
        if (o !== 13'h1800) begin fails++; $display("FAIL mid_postrst got %h want %h", o, 13'h1800); end
      end
      tick();
    end
    rst = 1'b0;
    clean();
  endtask

  task automatic test_random();
    logic [12:0] o;
    logic [12:0] e;
    logic h;
    h = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(15) == 0) h = ~h;
      rst = ($urandom_range(399) == 0);
      drive(h, $urandom_range(49) == 0, 1'($urandom_range(1)), $urandom_range(2) == 0,
            1'($urandom_range(1)), $urandom_range(2) == 0);
      @(negedge clk);
      o = obs(); e = m_exp();
      tests++;
      if (o !== e) begin fails++; $display("FAIL rand_model i=%0d got %h want %h", i, o, e); end
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    test_reset();
    test_idle_halt();
    test_drain();
    test_saturation();
    test_underflow();
    test_halt_abort();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
